// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/execute sequencer for the A/B accumulator datapath
module instr_sequencer #(
  parameter int              PC_W    = 8,
  parameter int              OP_W    = 7,
  parameter int              LIT_W   = 8,
  parameter logic [OP_W-1:0] HALT_OP = {OP_W{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  imem_req,
  output logic [PC_W-1:0]       imem_addr,
  input  logic                  imem_ack,
  input  logic [OP_W+LIT_W-1:0] imem_data,
  output logic [OP_W-1:0]       opcode,
  output logic [LIT_W-1:0]      lit,
  output logic                  exec_en,
  output logic [PC_W-1:0]       pc,
  output logic                  busy,
  output logic                  halted,
  output logic [15:0]           retired
);

  localparam int IW = OP_W + LIT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [15:0]     retired_q, retired_d;

  // Next-state logic: capture on acked fetch, count retirements, restart from HALT at address 0
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d = imem_data;
          if (imem_data[IW-1:LIT_W] == HALT_OP) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = pc_q;
  assign exec_en   = (state_q == ST_EXEC);
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign halted    = (state_q == ST_HALT);
  assign pc        = pc_q;
  assign opcode    = ir_q[IW-1:LIT_W];
  assign lit       = ir_q[LIT_W-1:0];
  assign retired   = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer
module tb_instr_sequencer;

  localparam logic [6:0] HALT = 7'h7F;

  logic        clk = 1'b0;
  logic        rst, start, imem_ack;
  logic [14:0] imem_data;
  logic        imem_req, exec_en, busy, halted;
  logic [7:0]  imem_addr, pc, lit;
  logic [6:0]  opcode;
  logic [15:0] retired;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .opcode(opcode), .lit(lit), .exec_en(exec_en), .pc(pc),
    .busy(busy), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory and responder controls
  logic [14:0] mem [256];
  int  wait_cfg  = 0;
  int  wait_cnt  = 0;
  bit  force_ack = 0;
  bit  hold_ack  = 0;
  bit  cmp_en    = 0;

  // Behavioural model: activity flags plus architectural values
  bit          m_active = 0;
  bit          m_exec   = 0;
  bit          m_halted = 0;
  int          m_pc     = 0;
  logic [14:0] m_ir     = '0;
  int          m_ret    = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_exec = 0; m_halted = 0; m_pc = 0; m_ir = '0; m_ret = 0;
    end else if (m_exec) begin
      m_exec = 0;
      if (m_ret < 65535) m_ret = m_ret + 1;
    end else if (m_active) begin
      if (imem_ack) begin
        m_ir = imem_data;
        if (imem_data[14:8] == HALT) begin
          m_active = 0;
          m_halted = 1;
        end else begin
          m_pc   = (m_pc + 1) % 256;
          m_exec = 1;
        end
      end
    end else if (start) begin
      if (m_halted) m_pc = 0;
      m_halted = 0;
      m_active = 1;
    end
  end

  // Every-cycle compare against the model, then memory response for this cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_req",     imem_req,  32'(m_active && !m_exec));
      chk("m_addr",    imem_addr, 32'(m_pc));
      chk("m_pc",      pc,        32'(m_pc));
      chk("m_exec",    exec_en,   32'(m_exec));
      chk("m_busy",    busy,      32'(m_active));
      chk("m_halted",  halted,    32'(m_halted));
      chk("m_opcode",  opcode,    32'(m_ir[14:8]));
      chk("m_lit",     lit,       32'(m_ir[7:0]));
      chk("m_retired", retired,   32'(m_ret));
    end
    if (force_ack) begin
      imem_ack  = 1'b1;
      imem_data = mem[imem_addr];
    end else if (imem_req && !hold_ack) begin
      if (wait_cnt < wait_cfg) begin
        imem_ack = 1'b0;
        wait_cnt++;
      end else begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr];
        wait_cnt  = 0;
      end
    end else begin
      imem_ack = 1'b0;
    end
  end

  logic [1:6] exp_req = 6'b101010;
  logic [1:6] exp_ex  = 6'b010100;

  initial begin
    bit found;
    int nreq, addr_bad, n_exec, pc_at_exec;

    imem_ack = 1'b0; imem_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = {7'h02, 8'h05};
    mem[1] = {7'h06, 8'h03};
    mem[2] = {HALT,  8'h00};

    // Reset held two cycles with start and ack asserted
    rst = 1; start = 1; force_ack = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_exec", exec_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 0);
    chk("rst_opcode", opcode, 0);
    rst = 0; start = 0; force_ack = 0; cmp_en = 1;

    // Zero-wait program, with a stray start during the second fetch
    @(negedge clk);
    start = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = (c == 3);
      chk("zw_req", imem_req, 32'(exp_req[c]));
      chk("zw_exec", exec_en, 32'(exp_ex[c]));
      if (c == 2) begin chk("zw_op0", opcode, 32'h02); chk("zw_lit0", lit, 32'h05); end
      if (c == 4) begin chk("zw_op1", opcode, 32'h06); chk("zw_lit1", lit, 32'h03); end
    end
    chk("zw_halted", halted, 1);
    chk("zw_pc", pc, 2);
    chk("zw_retired", retired, 2);

    // Restart from HALT
    start = 1;
    @(negedge clk);
    start = 0;
    chk("rs_pc", pc, 0);
    chk("rs_req", imem_req, 1);
    chk("rs_addr", imem_addr, 0);
    chk("rs_halted", halted, 0);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (halted) begin found = 1; break; end
    end
    chk("rs_rehalt", 32'(found), 1);
    chk("rs_retired", retired, 4);

    // Wait states: three stall cycles per fetch
    rst = 1;
    @(negedge clk);
    rst = 0;
    mem[1] = {HALT, 8'h00};
    wait_cfg = 3;
    start = 1;
    nreq = 0; addr_bad = 0; n_exec = 0; pc_at_exec = -1; found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 0;
      if (imem_req && n_exec == 0) begin
        nreq++;
        if (imem_addr != 0) addr_bad++;
      end
      if (exec_en) begin n_exec++; pc_at_exec = pc; end
      if (halted) begin found = 1; break; end
    end
    chk("ws_halt", 32'(found), 1);
    chk("ws_nreq", 32'(nreq), 4);
    chk("ws_addr", 32'(addr_bad), 0);
    chk("ws_nexec", 32'(n_exec), 1);
    chk("ws_pc", 32'(pc_at_exec), 1);

    // PC wrap over 256 words
    rst = 1;
    @(negedge clk);
    rst = 0;
    wait_cfg = 0;
    for (int i = 0; i < 256; i++) mem[i] = {7'h24, 8'h01};
    start = 1;
    n_exec = 0; found = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      start = 0;
      if (exec_en) n_exec++;
      if (n_exec == 256) begin found = 1; break; end
    end
    chk("wr_done", 32'(found), 1);
    @(negedge clk);
    chk("wr_addr", imem_addr, 0);
    chk("wr_pc", pc, 0);
    chk("wr_retired", retired, 256);
    chk("wr_halted", halted, 0);

    // Reset during a stalled fetch at pc=3, then stray acks while idle
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (exec_en && pc == 3) begin found = 1; break; end
    end
    chk("rf_reach", 32'(found), 1);
    hold_ack = 1;
    @(negedge clk);
    chk("rf_stall_req", imem_req, 1);
    chk("rf_stall_pc", pc, 3);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rf_req", imem_req, 0);
    chk("rf_pc", pc, 0);
    chk("rf_exec", exec_en, 0);
    hold_ack = 0;
    force_ack = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rf_ign_exec", exec_en, 0);
      chk("rf_ign_busy", busy, 0);
      chk("rf_ign_pc", pc, 0);
    end
    force_ack = 0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle fetch/execute sequencer for the 8-bit A/B accumulator datapath.
- Fetches {opcode, literal} words from instruction memory over a req/ack handshake.
- Holds each word in an instruction register and feeds the opcode to the combinational control unit and the literal to Mux B.
- Emits a one-cycle execute strobe that qualifies the LA/LB register loads.
- Stops on a dedicated HALT opcode.

## Interface
- PC_W, default 8: program counter and instruction address width.
- OP_W, default 7: opcode width; must match the control unit opcode input.
- LIT_W, default 8: literal (k8) width; must match datapath width.
- HALT_OP, default 7'b1111111: opcode that stops the sequencer.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  run request; sampled only in IDLE and HALT.
- imem_req  out  1  fetch request, Moore output of state FETCH.
- imem_addr  out  PC_W  fetch address, equal to pc.
- imem_ack  in  1  memory has valid imem_data this cycle; ignored when imem_req=0.
- imem_data  in  OP_W+LIT_W  instruction word, {opcode[OP_W+LIT_W-1:LIT_W], literal[LIT_W-1:0]}.
- opcode  out  OP_W  instruction register opcode field, to control unit.
- lit  out  LIT_W  instruction register literal field, to Mux B k8 input.
- exec_en  out  1  execute strobe; top level ANDs LA/LB with it.
- pc  out  PC_W  current program counter.
- busy  out  1  high in FETCH or EXEC.
- halted  out  1  high in HALT.
- retired  out  16  count of executed instructions, saturating.

## Operation
States and transitions:
- IDLE: all strobes low. start=1 -> FETCH.
- FETCH: imem_req=1 and imem_addr=pc, both held stable until ack.
  - imem_ack=0: stay in FETCH.
  - imem_ack=1 and opcode field != HALT_OP: IR <= imem_data, pc <= pc+1, go to EXEC.
  - imem_ack=1 and opcode field == HALT_OP: IR <= imem_data, pc unchanged (still points at the HALT word), go to HALT. No exec_en, retired unchanged.
- EXEC: exec_en=1 for exactly one cycle; retired <= retired+1 (saturates at 16'hFFFF); go to FETCH.
- HALT: halted=1. start=1 -> pc <= 0, go to FETCH. IR is kept.

Rules:
- pc wraps from 2^PC_W-1 to 0 with no flag.
- start is ignored in FETCH and EXEC.
- imem_ack without imem_req has no effect.
- opcode/lit change only on a FETCH capture. Outside EXEC they are don't-care to the datapath because exec_en gates every load.
- Reset values: state IDLE, pc=0, IR=0 (opcode=0, lit=0), retired=0, imem_req=0, exec_en=0, busy=0, halted=0.
- Reset wins over every other event in the same cycle, including mid-FETCH and mid-EXEC. A pending fetch is abandoned with no capture.

## Timing
- start sampled high at edge N -> imem_req high in cycle N+1.
- Zero-wait memory (ack in the same cycle as req): 2 cycles per instruction, FETCH then EXEC.
- Each wait cycle (ack low) adds one cycle. imem_addr is constant throughout.
- IR capture, pc increment and the state change all happen at the edge where req&ack=1. exec_en is high in the following cycle.
- The ALU result is written at the edge that ends the EXEC cycle. The next FETCH overlaps nothing.
- halted rises the cycle after the HALT word is acked.
- All outputs are registered or decoded from state only; there is no combinational path from imem_ack to imem_req.

## Test plan
- Reset: hold rst 2 cycles with start=1 and ack=1 -> pc=0, imem_req=0, exec_en=0, busy=0, halted=0, retired=0, opcode=0.
- Zero-wait program: mem[0]={7'h02,8'h05}, mem[1]={7'h06,8'h03}, mem[2]={HALT_OP,8'h00}; start at cycle 0.
  - imem_req high in cycles 1, 3, 5.
  - exec_en in cycle 2 (opcode 02, lit 05) and cycle 4 (opcode 06, lit 03).
  - halted from cycle 6; pc=2, retired=2.
- Wait states: ack delayed 3 cycles on address 0 -> req high for 4 cycles with imem_addr=0 throughout, a single exec_en, pc=1 afterwards.
- PC wrap: 256 words of {7'h24,8'h01} and zero-wait memory -> after 256 exec_en pulses, imem_addr returns to 0, pc=0, retired=256, halted=0.
- Reset mid-fetch: rst asserted during FETCH with ack=0 at pc=3 -> next cycle state IDLE, imem_req=0, pc=0, no exec_en. A later ack is ignored.
- Restart and ignore rules: start pulse during FETCH changes nothing; start in HALT with pc=2 -> pc=0, imem_req high next cycle with imem_addr=0, halted low.
